// File: rtl/serial_adder_driver_if.sv
// Word-side handshakes and bit-serial adder link for serial_adder_driver.
// slave is the driver's view; master is the producer/consumer/adder side.
interface serial_adder_driver_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         ser_clr;
    logic         ser_a;
    logic         ser_b;
    logic         ser_sum;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_sum;

    modport slave (
        input  in_valid, in_a, in_b, ser_sum, out_ready,
        output in_ready, ser_clr, ser_a, ser_b, out_valid, out_sum
    );

    modport master (
        output in_valid, in_a, in_b, ser_sum, out_ready,
        input  in_ready, ser_clr, ser_a, ser_b, out_valid, out_sum
    );
endinterface

// File: rtl/serial_adder_driver.sv
// Parallel-to-serial front end for a bit-serial adder: clears the adder carry,
// streams both operands LSB-first, plus one flush bit, and collects the W+1-bit sum.
module serial_adder_driver #(
    parameter int unsigned W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_adder_driver_if.slave  bus
);
    localparam int unsigned IW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  sh_a;
    logic [W-1:0]  sh_b;
    logic [IW-1:0] idx;
    logic [W:0]    result;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Operand registers shift in zeros, so the flush cycle (idx == W) drives 0/0 for free.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.ser_clr   = 1'b1;
        bus.ser_a     = 1'b0;
        bus.ser_b     = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = CLEAR;
            end
            CLEAR: state_nxt = SHIFT;
            SHIFT: begin
                bus.ser_clr = 1'b0;
                bus.ser_a   = sh_a[0];
                bus.ser_b   = sh_b[0];
                if (idx == IW'(W)) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result fills from the top: after W+1 shifts bit 0 holds the first sum bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_a   <= '0;
            sh_b   <= '0;
            idx    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sh_a <= bus.in_a;
                        sh_b <= bus.in_b;
                        idx  <= '0;
                    end
                end
                SHIFT: begin
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    idx    <= idx + IW'(1);
                    result <= {bus.ser_sum, result[W:1]};
                end
                default: ;
            endcase
        end
    end

    assign bus.out_sum = result;
endmodule

// File: tb/tb_serial_adder_driver.sv
// Bench for serial_adder_driver: a bit-serial adder model closes the loop and
// results are compared against plain a + b arithmetic.
module tb_serial_adder_driver;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_adder_driver_if #(.W(W)) bus ();

    serial_adder_driver #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Serial adder with synchronous active-high clear; sum is X whenever cleared.
    logic carry;
    always @(posedge clk)
        carry <= bus.ser_clr ? 1'b0 :
                 ((bus.ser_a & bus.ser_b) | (carry & (bus.ser_a ^ bus.ser_b)));
    assign bus.ser_sum = bus.ser_clr ? 1'bx : (bus.ser_a ^ bus.ser_b ^ carry);

    int checks   = 0;
    int failures = 0;

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int edges, output logic ok);
        logic acc;
        ok = 1'b0;
        edges = 0;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            acc = bus.in_ready;
            step();
            edges++;
            ok = acc;
        end
        bus.in_valid = 1'b0;
        bus.in_a = W'($urandom);
        bus.in_b = W'($urandom);
    endtask

    task automatic wait_valid(output int cyc, output logic [W:0] abits);
        int k;
        k = 0;
        cyc = 0;
        abits = '0;
        while (!bus.out_valid && cyc < 64) begin
            step();
            cyc++;
            if (!bus.ser_clr && k <= int'(W)) begin
                abits[k] = bus.ser_a;
                k++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        step(); step(); step();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.ser_clr !== 1'b1) begin failures++; $display("FAIL reset_ser_clr: got %b expected 1", bus.ser_clr); end
        checks++; if ({bus.ser_a, bus.ser_b} !== 2'b00) begin failures++; $display("FAIL reset_ser_ab: got %b%b expected 00", bus.ser_a, bus.ser_b); end
        checks++; if (bus.out_sum !== '0) begin failures++; $display("FAIL reset_out_sum: got %h expected 0", bus.out_sum); end
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int e, cyc;
        logic ok;
        logic [W:0] abits;
        logic [W-1:0] a, b;
        a = 8'h05;
        b = 8'h03;
        bus.out_ready = 1'b0;
        offer(a, b, e, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_accept: got %b expected 1", ok); end
        wait_valid(cyc, abits);
        checks++; if (cyc != int'(W) + 2) begin failures++; $display("FAIL basic_latency: got %0d expected %0d", cyc, W + 2); end
        checks++; if (bus.out_sum !== ref_sum(a, b)) begin failures++; $display("FAIL basic_sum: got %h expected %h", bus.out_sum, ref_sum(a, b)); end
        checks++; if (abits !== {1'b0, a}) begin failures++; $display("FAIL basic_ser_a_bits: got %b expected %b", abits, {1'b0, a}); end
        bus.out_ready = 1'b1;
        step();
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin failures++; $display("FAIL basic_release: got valid/ready %b%b expected 01", bus.out_valid, bus.in_ready); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] pa [4];
        logic [W-1:0] pb [4];
        int e, cyc;
        logic ok;
        logic [W:0] abits;
        pa = '{8'hFF, 8'hFF, 8'h00, 8'h80};
        pb = '{8'h01, 8'hFF, 8'h00, 8'h80};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(pa[i], pb[i], e, ok);
            checks++; if (!ok || (i > 0 && e != 2)) begin failures++; $display("FAIL b2b_accept_%0d: got ok=%b edges=%0d expected ok=1 edges=2", i, ok, e); end
            wait_valid(cyc, abits);
            checks++; if (bus.out_sum !== ref_sum(pa[i], pb[i]) || $isunknown(bus.out_sum)) begin failures++; $display("FAIL b2b_sum_%0d: got %h expected %h", i, bus.out_sum, ref_sum(pa[i], pb[i])); end
        end
        step();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        int e, cyc;
        logic ok, seen;
        logic [W:0] abits, exp;
        logic [W-1:0] a, b;
        a = W'($urandom);
        b = W'($urandom);
        exp = ref_sum(a, b);
        bus.out_ready = 1'b0;
        offer(a, b, e, ok);
        wait_valid(cyc, abits);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i == 1);
            bus.in_a = 8'h11;
            bus.in_b = 8'h22;
            checks++; if ({bus.out_valid, bus.in_ready} !== 2'b10 || bus.out_sum !== exp) begin failures++; $display("FAIL bp_hold_%0d: got valid/ready %b%b sum %h expected 10 sum %h", i, bus.out_valid, bus.in_ready, bus.out_sum, exp); end
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin failures++; $display("FAIL bp_release: got valid/ready %b%b expected 01", bus.out_valid, bus.in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (bus.out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL bp_ignored_input: got out_valid=%b expected 0", seen); end
    endtask

    task automatic test_reset_mid_shift();
        int e, cyc;
        logic ok, seen;
        logic [W:0] abits;
        bus.out_ready = 1'b1;
        offer(8'hAA, 8'h55, e, ok);
        step(); step(); step(); step();
        checks++; if ({bus.ser_clr, bus.ser_a, bus.ser_b} !== 3'b010) begin failures++; $display("FAIL mid_bit3: got clr/a/b %b%b%b expected 010", bus.ser_clr, bus.ser_a, bus.ser_b); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++; if ({bus.in_ready, bus.out_valid} !== 2'b10 || bus.out_sum !== '0) begin failures++; $display("FAIL mid_reset_state: got ready/valid %b%b sum %h expected 10 sum 0", bus.in_ready, bus.out_valid, bus.out_sum); end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_result: got out_valid=%b expected 0", seen); end
        offer(8'h12, 8'h34, e, ok);
        wait_valid(cyc, abits);
        checks++; if (bus.out_sum !== ref_sum(8'h12, 8'h34) || cyc != int'(W) + 2) begin failures++; $display("FAIL mid_followup: got %h after %0d expected %h after %0d", bus.out_sum, cyc, ref_sum(8'h12, 8'h34), W + 2); end
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        int e, delivered, bad;
        logic ok, hs, r;
        logic [W:0] snap, got, exp;
        logic [W-1:0] a, b;
        delivered = 0;
        for (int n = 0; n < 200; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            exp = ref_sum(a, b);
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
            offer(a, b, e, ok);
            got = 'x;
            bad = 1;
            for (int i = 0; i < 200; i++) begin
                r = 1'($urandom_range(0, 1));
                bus.out_ready = r;
                hs = bus.out_valid && r;
                snap = bus.out_sum;
                step();
                if (hs) begin
                    delivered++;
                    got = snap;
                    bad = 0;
                    break;
                end
            end
            bus.out_ready = 1'b0;
            checks++; if (bad != 0 || !ok || got !== exp) begin failures++; $display("FAIL rand_%0d: %h+%h got %h expected %h", n, a, b, got, exp); end
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rand_once_%0d: got out_valid=%b expected 0", n, bus.out_valid); end
        end
        checks++; if (delivered != 200) begin failures++; $display("FAIL rand_delivered: got %0d expected 200", delivered); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.out_ready = 1'b0;
        step();
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_adder_driver.md
# serial_adder_driver

Word-level front end for the team's bit-serial adders. It accepts two parallel W-bit operands over a valid/ready handshake and clears the adder's carry register. It then shifts both operands out LSB-first as `ser_a`/`ser_b`, collects the returned `ser_sum` bit stream and presents the W+1-bit parallel result over a second valid/ready handshake. It sits between a word-oriented producer/consumer and any serial adder whose carry register is reset by an active-high synchronous clear.

## Interface
- `W`, default 8: operand width in bits; legal range 1..32.

- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  one clock; reset is synchronous and active-low (`rst` = 0 resets on the next posedge).
- `in_valid`  in  1  producer offers an operand pair.
- `in_ready`  out  1  driver accepts a pair; high only in IDLE.
- `in_a`  in  W  operand A; sampled only on the accept edge.
- `in_b`  in  W  operand B; sampled only on the accept edge.
- `ser_clr`  out  1  active-high synchronous clear for the serial adder's carry; connects to the adder's reset.
- `ser_a`  out  1  serial operand A, LSB first.
- `ser_b`  out  1  serial operand B, LSB first.
- `ser_sum`  in  1  combinational sum bit from the serial adder, for the bits currently driven on `ser_a`/`ser_b`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  W+1  `in_a + in_b` zero-extended; bit W is the carry out.

## Operation
- States:
  - IDLE → CLEAR on `in_valid & in_ready`.
  - CLEAR → SHIFT after 1 cycle.
  - SHIFT → DONE after W+1 cycles.
  - DONE → IDLE on `out_valid & out_ready`.
- Accept edge:
  - `in_a`/`in_b` are copied into internal shift registers, so inputs may change afterwards.
  - The bit index is cleared to 0.
- IDLE and CLEAR: `ser_clr` = 1, `ser_a` = `ser_b` = 0. This guarantees the adder carry is 0 before bit 0.
- SHIFT, bit index k = 0..W-1:
  - `ser_clr` = 0, `ser_a` = A[k], `ser_b` = B[k].
  - On each SHIFT edge, `ser_sum` is shifted into result bit k.
- SHIFT, k = W (flush cycle): `ser_a` = `ser_b` = 0, so `ser_sum` equals the final carry and is stored as `out_sum[W]`.
- `ser_sum` is ignored outside SHIFT; X on it in other states must not propagate.
- DONE:
  - `out_valid` = 1; `ser_clr` = 1; `ser_a` = `ser_b` = 0.
  - `out_sum` is held stable until the output handshake.
  - `in_valid` is ignored.
- Arithmetic: unsigned, no saturation. The full W+1-bit result is always correct, including `2^W - 1 + 2^W - 1`.
- Reset (`rst` = 0), effective on any state including mid-SHIFT:
  - State returns to IDLE; any operation in flight is discarded and no `out_valid` is produced for it.
  - `out_sum`, the shift registers and the bit index are cleared to 0.
- Reset values of outputs: `in_ready` = 1, `ser_clr` = 1, `ser_a` = 0, `ser_b` = 0, `out_valid` = 0, `out_sum` = 0.

## Timing
- Accept at edge E0: CLEAR spans E0..E1; bit k is sampled at edge E(k+2); the flush bit is sampled at E(W+2).
- `out_valid` rises after edge E(W+2), i.e. W+2 cycles after the accept edge.
- With `out_ready` held high, the output handshake completes at E(W+3). IDLE follows, and the next accept is possible at E(W+4).
- Minimum initiation interval: W+4 cycles.
- `in_ready` and `out_valid` are pure functions of state: no combinational path from `in_valid` or `out_ready`.
- `ser_a`, `ser_b` and `ser_clr` are registered or state-decoded only. `ser_sum` → result-register is the only path from the adder.
- Simultaneous events:
  - `in_valid` high in DONE: not accepted.
  - `rst` low together with an input or output handshake: reset wins and neither handshake completes.

## Test plan
- W=8, accept 0x05 + 0x03 → `out_sum` = 9'h008, with `out_valid` rising exactly W+2=10 cycles after the accept edge. `ser_a` reads 1,0,1,0,0,0,0,0,0 on the bit edges.
- 0xFF + 0x01 → 9'h100; 0xFF + 0xFF → 9'h1FE. Then back-to-back 0x00 + 0x00 → 9'h000, proving the carry is cleared between operations.
- Backpressure: hold `out_ready` = 0 for 5 cycles after `out_valid`.
  - `out_valid` stays 1 and `out_sum` stays stable; `in_ready` stays 0.
  - An `in_valid` pulse with 0x11 + 0x22 during that window is not accepted.
  - After release, `in_ready` = 1 on the next cycle.
- Drive `rst` = 0 for one cycle during SHIFT at bit 3 of 0xAA + 0x55.
  - No `out_valid` appears; `in_ready` = 1 on the first cycle after release.
  - A following 0x12 + 0x34 → 9'h046.
- Hold `ser_sum` = X in IDLE, CLEAR and DONE → `out_sum` is never X.
- 200 random pairs with a random `out_ready` duty cycle against a reference `a + b` → all match, every result is delivered exactly once, and no operands are lost.
